// File: rtl/toggle_detect.sv
// -----------------------------------------------------------------------------
// toggle_detect
//
// Receive side of a toggle-encoded event link. The incoming level t_in changes
// once per event; this block synchronizes it, detects each accepted change,
// emits a one-cycle pulse, raises a pending flag for a req/ack consumer, flags
// events that arrive while one is still unacknowledged, and keeps a wrapping
// count of detected events.
//
// Optional feature macro: TOGGLE_DEBOUNCE_EN
//   When defined, a change at the synchronizer output must stay stable for
//   DB_CYCLES consecutive cycles before it is accepted; shorter glitches are
//   discarded. When undefined, every change is accepted after synchronization.
//
// Parameters:
//   CNT_W      width of the event counter
//   DB_CYCLES  debounce stability length in cycles (debounce builds only, >= 1)
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   t_in       asynchronous toggle-encoded event input
//   evt_ack    consumer acknowledge of the pending event
//   cnt_clr    synchronous clear of count and overflow flag
//   tgl_pulse  one-cycle pulse per detected toggle
//   evt_pend   event pending (request to consumer)
//   evt_ovf    sticky: event detected while a previous one was still pending
//   level      accepted (synchronized) level of t_in
//   count      number of detected toggles, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module toggle_detect #(
    parameter int CNT_W     = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_in,
    input  logic             evt_ack,
    input  logic             cnt_clr,
    output logic             tgl_pulse,
    output logic             evt_pend,
    output logic             evt_ovf,
    output logic             level,
    output logic [CNT_W-1:0] count
);

    // Two warm-up edges after reset, then RUN until the next reset.
    typedef enum logic [1:0] {
        ST_WARM0 = 2'd0,
        ST_WARM1 = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_pulse;
    logic             r_pend;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;

    logic             w_level_nxt;
    logic             w_pulse_nxt;
    logic             w_pend_nxt;
    logic             w_ovf_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    logic             w_run;
    logic             w_diff;
    logic             w_detect;

`ifdef TOGGLE_DEBOUNCE_EN
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] r_db_cnt;
    logic [DB_W-1:0] w_db_cnt_nxt;
`endif

    assign w_run  = (r_state == ST_RUN);
    assign w_diff = (r_s2 != r_level);

`ifdef TOGGLE_DEBOUNCE_EN
    // Accept a change only once it has been seen for DB_CYCLES RUN edges.
    assign w_detect = w_run && w_diff && (r_db_cnt == DB_LAST);

    always_comb begin
        w_db_cnt_nxt = '0;
        if (w_run && w_diff && !w_detect) begin
            w_db_cnt_nxt = r_db_cnt + DB_W'(1);
        end
    end
`else
    assign w_detect = w_run && w_diff;
`endif

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_pulse_nxt = 1'b0;
        w_pend_nxt  = r_pend;
        w_ovf_nxt   = r_ovf;
        w_count_nxt = r_count;

        case (r_state)
            ST_WARM0: w_state_nxt = ST_WARM1;
            ST_WARM1: w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_WARM0;
        endcase

        // During warm-up level follows the value s2 is being loaded with, so
        // level and s2 agree on RUN entry and a level held across reset
        // produces no event.
        if (!w_run) begin
            w_level_nxt = r_s1;
        end else if (w_detect) begin
            w_level_nxt = r_s2;
        end

        w_pulse_nxt = w_detect;

        // Handshake: a new event always leaves a request pending; it only
        // counts as an overflow if the previous one was neither acked now
        // nor earlier.
        if (w_detect) begin
            if (r_pend && !evt_ack) begin
                w_ovf_nxt = 1'b1;
            end
            w_pend_nxt = 1'b1;
        end else if (evt_ack) begin
            w_pend_nxt = 1'b0;
        end

        // Clear takes priority over the overflow set above; a simultaneous
        // event is still counted.
        if (cnt_clr) begin
            w_ovf_nxt   = 1'b0;
            w_count_nxt = w_detect ? CNT_W'(1) : '0;
        end else if (w_detect) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WARM0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_pend  <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s1    <= t_in;
            r_s2    <= r_s1;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
            r_pend  <= w_pend_nxt;
            r_ovf   <= w_ovf_nxt;
            r_count <= w_count_nxt;
        end
    end

`ifdef TOGGLE_DEBOUNCE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= w_db_cnt_nxt;
        end
    end
`endif

    assign tgl_pulse = r_pulse;
    assign evt_pend  = r_pend;
    assign evt_ovf   = r_ovf;
    assign level     = r_level;
    assign count     = r_count;

endmodule

// File: tb/tb_toggle_detect.sv
module tb_toggle_detect;

`ifdef TOGGLE_DEBOUNCE_EN
    localparam int DB      = 4;
    localparam int EXP_LAT = 6;   // pulse seen at the 6th negedge after the change
    localparam int EXP_GLITCH_PULSES = 0;
`else
    localparam int DB      = 1;
    localparam int EXP_LAT = 3;
    localparam int EXP_GLITCH_PULSES = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       t_in = 1'b0;
    logic       evt_ack = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       a_pulse, a_pend, a_ovf, a_level;
    logic [7:0] a_count;
    logic       b_pulse, b_pend, b_ovf, b_level;
    logic [1:0] b_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    toggle_detect #(.CNT_W(8), .DB_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .t_in(t_in), .evt_ack(evt_ack), .cnt_clr(cnt_clr),
        .tgl_pulse(a_pulse), .evt_pend(a_pend), .evt_ovf(a_ovf),
        .level(a_level), .count(a_count)
    );

    toggle_detect #(.CNT_W(2), .DB_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .t_in(t_in), .evt_ack(evt_ack), .cnt_clr(cnt_clr),
        .tgl_pulse(b_pulse), .evt_pend(b_pend), .evt_ovf(b_ovf),
        .level(b_level), .count(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: t_in is seen two edges late; a change is accepted
    // once the delayed input has disagreed with the accepted level on the
    // last DB run edges.
    bit          samples[$];
    bit          window[$];
    int          m_edges = 0;
    bit          m_valid = 0;
    bit          m_level, m_pulse, m_pend, m_ovf;
    logic [31:0] m_count;

    always @(posedge clk) begin
        bit d;
        bit det;
        if (rst) begin
            samples.delete();
            window.delete();
            m_edges = 0;
            m_valid = 1;
            m_level = 0; m_pulse = 0; m_pend = 0; m_ovf = 0; m_count = 0;
        end else if (m_valid) begin
            d   = (samples.size() >= 2) ? samples[samples.size()-2] : 1'b0;
            det = 0;
            m_edges++;
            if (m_edges <= 2) begin
                m_level = (samples.size() > 0) ? samples[samples.size()-1] : 1'b0;
            end else begin
                window.push_back(d);
                while (window.size() > DB) void'(window.pop_front());
                if (window.size() == DB) begin
                    det = 1;
                    foreach (window[j]) if (window[j] == m_level) det = 0;
                end
            end
            if (det) m_level = d;
            m_pulse = det;
            if (det) begin
                if (m_pend && !evt_ack) m_ovf = 1;
                m_pend = 1;
            end else if (evt_ack) begin
                m_pend = 0;
            end
            if (cnt_clr) begin
                m_ovf   = 0;
                m_count = det ? 32'd1 : 32'd0;
            end else if (det) begin
                m_count = m_count + 1;
            end
            samples.push_back(t_in);
            while (samples.size() > 2) void'(samples.pop_front());
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pulse_a", {31'd0, a_pulse}, {31'd0, m_pulse});
            chk("pend_a",  {31'd0, a_pend},  {31'd0, m_pend});
            chk("ovf_a",   {31'd0, a_ovf},   {31'd0, m_ovf});
            chk("level_a", {31'd0, a_level}, {31'd0, m_level});
            chk("count_a", {24'd0, a_count}, {24'd0, m_count[7:0]});
            chk("pulse_b", {31'd0, b_pulse}, {31'd0, m_pulse});
            chk("pend_b",  {31'd0, b_pend},  {31'd0, m_pend});
            chk("ovf_b",   {31'd0, b_ovf},   {31'd0, m_ovf});
            chk("count_b", {30'd0, b_count}, {30'd0, m_count[1:0]});
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input bit tv);
        @(negedge clk);
        rst = 1; t_in = tv; evt_ack = 0; cnt_clr = 0;
        nclk(2);
        rst = 0;
        nclk(4);
    endtask

    // Toggle t_in and watch for the pulse; returns its negedge index and count.
    task automatic toggle_watch(output int lat, output int npulse);
        t_in = ~t_in;
        lat = -1; npulse = 0;
        for (int i = 1; i <= DB + 6; i++) begin
            @(negedge clk); #1;
            if (a_pulse) begin
                if (lat < 0) lat = i;
                npulse++;
            end
        end
    endtask

    task automatic ack_one();
        evt_ack = 1; nclk(1); evt_ack = 0;
    endtask

    initial begin
        int lat, np, pulses, c0;
        int exp_b[5];
        exp_b = '{1, 2, 3, 0, 1};

        // 1: level held high across reset produces no event
        do_reset(1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (a_pulse) pulses++;
        end
        chk("t1_level", {31'd0, a_level}, 32'd1);
        chk("t1_pulses", pulses, 32'd0);
        chk("t1_count", {24'd0, a_count}, 32'd0);
        chk("t1_pend", {31'd0, a_pend}, 32'd0);

        // 2: single rising change, latency and side effects
        do_reset(1'b0);
        toggle_watch(lat, np);
        chk("t2_latency", lat, EXP_LAT);
        chk("t2_npulse", np, 32'd1);
        chk("t2_pend", {31'd0, a_pend}, 32'd1);
        chk("t2_count", {24'd0, a_count}, 32'd1);
        chk("t2_level", {31'd0, a_level}, 32'd1);

        // 3: three unacked events, then clear, then ack
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) toggle_watch(lat, np);
        chk("t3_count", {24'd0, a_count}, 32'd3);
        chk("t3_pend", {31'd0, a_pend}, 32'd1);
        chk("t3_ovf", {31'd0, a_ovf}, 32'd1);
        cnt_clr = 1; nclk(1); cnt_clr = 0; #1;
        chk("t3_clr_count", {24'd0, a_count}, 32'd0);
        chk("t3_clr_ovf", {31'd0, a_ovf}, 32'd0);
        chk("t3_clr_pend", {31'd0, a_pend}, 32'd1);
        nclk(1);
        ack_one(); #1;
        chk("t3_ack_pend", {31'd0, a_pend}, 32'd0);

        // 4: detect coinciding with ack, then with clear
        do_reset(1'b0);
        toggle_watch(lat, np);
        t_in = ~t_in;
        nclk(1 + DB);
        evt_ack = 1; nclk(1); evt_ack = 0;
        nclk(3); #1;
        chk("t4_ack_pend", {31'd0, a_pend}, 32'd1);
        chk("t4_ack_ovf", {31'd0, a_ovf}, 32'd0);
        chk("t4_ack_count", {24'd0, a_count}, 32'd2);
        t_in = ~t_in;
        nclk(1 + DB);
        cnt_clr = 1; nclk(1); cnt_clr = 0;
        nclk(3); #1;
        chk("t4_clr_count", {24'd0, a_count}, 32'd1);
        chk("t4_clr_ovf", {31'd0, a_ovf}, 32'd0);
        chk("t4_clr_pend", {31'd0, a_pend}, 32'd1);

        // 5: 2-bit counter wrap, then reset while an event is pending
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) begin
            toggle_watch(lat, np);
            chk("t5_count_b", {30'd0, b_count}, exp_b[k]);
            if (k < 4) ack_one();
        end
        chk("t5_ovf_b", {31'd0, b_ovf}, 32'd0);
        chk("t5_pend_b", {31'd0, b_pend}, 32'd1);
        rst = 1; nclk(1); #1;
        chk("t5_rst_pend", {31'd0, b_pend}, 32'd0);
        chk("t5_rst_level", {31'd0, b_level}, 32'd0);
        chk("t5_rst_count", {30'd0, b_count}, 32'd0);
        chk("t5_rst_pulse", {31'd0, b_pulse}, 32'd0);
        rst = 0;
        nclk(6);

        // reset landing on an in-flight change: warm-up absorbs it
        t_in = ~t_in; nclk(1);
        rst = 1; nclk(1); rst = 0;
        nclk(10); #1;
        chk("t5_inflight_count", {24'd0, a_count}, 32'd0);
        chk("t5_inflight_pend", {31'd0, a_pend}, 32'd0);

        // 6: 2-cycle glitch (rejected with debounce, two events without)
        do_reset(1'b0);
        c0 = a_count;
        t_in = 1; nclk(2); t_in = 0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (a_pulse) pulses++;
        end
        chk("t6_glitch_pulses", pulses, EXP_GLITCH_PULSES);
        chk("t6_glitch_count", {24'd0, a_count}, c0 + EXP_GLITCH_PULSES);

        // 1-cycle glitch and back-to-back activity, checked by the model
        t_in = 1; nclk(1); t_in = 0; nclk(8);
        t_in = 1; nclk(3); t_in = 0; nclk(1); t_in = 1; evt_ack = 1; nclk(2); evt_ack = 0;
        nclk(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
